// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, FSM state encoding, 7-segment glyphs.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

  // ALU opcode encoding carried on req_op
  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NOT_A = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_SGT   = 3'b110,
    OP_EQ    = 3'b111
  } alu_op_e;

  // Sequencer states; the encoding is also what LEDR shows
  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ENTER_OP = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_RSP = 3'd4,
    ST_SHOW     = 3'd5
  } state_e;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Hex digit glyphs, element [n] is the glyph for value n
  localparam logic [15:0][6:0] SEG_DIGITS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_hex(input logic [3:0] val);
    return SEG_DIGITS[val];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the active-low KEY, debounces it and emits a one-cycle pulse per press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 cycle to the press pulse.
// Backpressure: none; presses are pulses that the consumer either uses or drops.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic KEY,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          press_q, press_d;

  // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYCLES cycles
  always_comb begin
    sync1_d = KEY;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = level_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; synchroniser and level reset to the released (high) key
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects A, B and an opcode from switches, issues one ALU command and shows the response.
// Latency: command offered the cycle after the opcode press; response shown the cycle after rsp_valid.
// Backpressure: req_valid/req_a/req_b/req_op hold until req_ready; no response within RSP_TIMEOUT flags an error.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RSP_TIMEOUT     = 1024
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       KEY,
  input  logic [3:0] SW,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [3:0] req_a,
  output logic [3:0] req_b,
  output logic [2:0] req_op,
  input  logic       rsp_valid,
  input  logic [3:0] rsp_result,
  input  logic       rsp_carry,
  input  logic       rsp_ovf,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [2:0] LEDR
);

  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);

  logic          press;
  state_e        state_q, state_d;
  logic [3:0]    a_q,     a_d;
  logic [3:0]    b_q,     b_d;
  alu_op_e       op_q,    op_d;
  logic [3:0]    res_q,   res_d;
  logic          carry_q, carry_d;
  logic          ovf_q,   ovf_d;
  logic          err_q,   err_d;
  logic [TW-1:0] tmo_q,   tmo_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .CLOCK_50(CLOCK_50),
    .RST     (RST),
    .KEY     (KEY),
    .press   (press)
  );

  // Next-state and datapath capture; the timeout counter only runs while waiting for a response
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    tmo_d   = '0;
    case (state_q)
      ST_ENTER_A: begin
        if (press) begin
          a_d     = SW;
          state_d = ST_ENTER_B;
        end
      end
      ST_ENTER_B: begin
        if (press) begin
          b_d     = SW;
          state_d = ST_ENTER_OP;
        end
      end
      ST_ENTER_OP: begin
        if (press) begin
          op_d    = alu_op_e'(SW[2:0]);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        // A response arriving on the last allowed cycle still wins over the timeout
        if (rsp_valid) begin
          res_d   = rsp_result;
          carry_d = rsp_carry;
          ovf_d   = rsp_ovf;
          err_d   = 1'b0;
          state_d = ST_SHOW;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_SHOW;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (press) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_ADD;
          res_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_ENTER_A;
        end
      end
      default: begin
        state_d = ST_ENTER_A;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= ST_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Command channel: valid is decoded from the state so reset drops it immediately
  always_comb begin
    req_valid = (state_q == ST_ISSUE);
    req_a     = a_q;
    req_b     = b_q;
    req_op    = op_q;
    LEDR      = state_q;
  end

  // Displays: a digit stays blank until its value has been captured in this transaction
  always_comb begin
    HEX0 = SEG_BLANK;
    HEX1 = SEG_BLANK;
    HEX2 = SEG_BLANK;
    HEX3 = SEG_BLANK;
    HEX4 = SEG_BLANK;
    HEX5 = SEG_BLANK;
    if (state_q != ST_ENTER_A) begin
      HEX5 = seg_hex(a_q);
    end
    if (state_q inside {ST_ENTER_OP, ST_ISSUE, ST_WAIT_RSP, ST_SHOW}) begin
      HEX4 = seg_hex(b_q);
    end
    if (state_q inside {ST_ISSUE, ST_WAIT_RSP, ST_SHOW}) begin
      HEX3 = seg_hex({1'b0, op_q});
    end
    if (state_q == ST_SHOW) begin
      if (err_q) begin
        HEX0 = SEG_E;
      end else begin
        HEX0 = seg_hex(res_q);
        HEX1 = seg_hex({3'b000, carry_q});
        HEX2 = seg_hex({3'b000, ovf_q});
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: table-driven entry, hand-written corner cases, randomized transactions.
// Latency: checks sampled on the falling edge, inputs driven right after it.
// Backpressure: the bench plays the ALU and chooses req_ready and response timing.
module tb_alu_cmd_sequencer;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_E = 7'b0000110;

  logic       CLOCK_50 = 1'b0;
  logic       RST;
  logic       KEY;
  logic [3:0] SW;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_ovf;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [2:0] LEDR;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase of the transaction and what has been captured so far
  int         m_st;
  logic [3:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic       m_c, m_v, m_err;

  typedef struct {
    logic [3:0] sw;
    logic [2:0] ledr;
    logic [6:0] h5;
    logic [6:0] h4;
    logic [6:0] h3;
  } entry_t;
  entry_t vec [3];

  alu_cmd_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .RSP_TIMEOUT    (8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RST       (RST),
    .KEY       (KEY),
    .SW        (SW),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_result(rsp_result),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5),
    .LEDR      (LEDR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ($signed(a) > $signed(b)) ? 4'd1 : 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_c = 0; m_v = 0; m_err = 0;
  endtask

  // Compare every output against what the captured values imply
  task automatic check_all(input string tag);
    logic show_rsp;
    show_rsp = (m_st == 5) && !m_err;
    chk({tag, "_ledr"},  32'(LEDR), 32'(m_st));
    chk({tag, "_valid"}, 32'(req_valid), 32'(m_st == 3));
    chk({tag, "_hex5"},  32'(HEX5), 32'((m_st >= 1) ? seg7(m_a) : BLANK));
    chk({tag, "_hex4"},  32'(HEX4), 32'((m_st >= 2) ? seg7(m_b) : BLANK));
    chk({tag, "_hex3"},  32'(HEX3), 32'((m_st >= 3) ? seg7({1'b0, m_op}) : BLANK));
    chk({tag, "_hex2"},  32'(HEX2), 32'(show_rsp ? seg7({3'b0, m_v}) : BLANK));
    chk({tag, "_hex1"},  32'(HEX1), 32'(show_rsp ? seg7({3'b0, m_c}) : BLANK));
    chk({tag, "_hex0"},  32'(HEX0), 32'((m_st == 5) ? (m_err ? GLYPH_E : seg7(m_res)) : BLANK));
    if (m_st == 3) begin
      chk({tag, "_req_a"},  32'(req_a),  32'(m_a));
      chk({tag, "_req_b"},  32'(req_b),  32'(m_b));
      chk({tag, "_req_op"}, 32'(req_op), 32'(m_op));
    end
  endtask

  // One clean press: long enough low and high holds to pass the debouncer both ways
  task automatic press();
    KEY = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    KEY = 1'b1;
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic model_press();
    case (m_st)
      0: begin m_a = SW; m_st = 1; end
      1: begin m_b = SW; m_st = 2; end
      2: begin m_op = SW[2:0]; m_st = 3; end
      5: model_reset();
      default: ;
    endcase
  endtask

  task automatic press_model(input string tag);
    press();
    model_press();
    check_all(tag);
  endtask

  // Enter A, B, OP, hold req_ready low rdy cycles, then transfer into WAIT_RSP
  task automatic enter_and_issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input int rdy);
    if (m_st == 5) press_model("clear");
    SW = a;  press_model("ent_a");
    SW = b;  press_model("ent_b");
    SW = {1'($urandom_range(1, 0)), op};
    press_model("ent_op");
    for (int i = 0; i < rdy; i++) begin
      @(negedge CLOCK_50);
      check_all("issue_hold");
    end
    req_ready = 1'b1;
    @(negedge CLOCK_50);
    req_ready = 1'b0;
    m_st = 4;
    check_all("xfer");
  endtask

  // Play the ALU: rsp_valid in WAIT_RSP cycle j; cycles past the timeout show the late case
  task automatic respond(input int j, input logic [3:0] r, input logic c, input logic v);
    for (int k = 0; k < 10; k++) begin
      rsp_valid  = (k == j);
      rsp_result = (k == j) ? r : 4'($urandom);
      rsp_carry  = (k == j) ? c : 1'($urandom);
      rsp_ovf    = (k == j) ? v : 1'($urandom);
      @(negedge CLOCK_50);
      if (m_st == 4) begin
        if (k == j) begin
          m_res = r; m_c = c; m_v = v; m_err = 0; m_st = 5;
        end else if (k == 7) begin
          m_err = 1; m_st = 5;
        end
      end
      check_all("wait");
    end
    rsp_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] ra, rb, rr;
    logic [2:0] rop;
    int rj;

    vec[0] = '{sw: 4'd5, ledr: 3'd1, h5: 7'b0010010, h4: BLANK,      h3: BLANK};
    vec[1] = '{sw: 4'd3, ledr: 3'd2, h5: 7'b0010010, h4: 7'b0110000, h3: BLANK};
    vec[2] = '{sw: 4'd1, ledr: 3'd3, h5: 7'b0010010, h4: 7'b0110000, h3: 7'b1111001};

    RST = 1'b1; KEY = 1'b1; SW = 4'd0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_result = 4'd0; rsp_carry = 1'b0; rsp_ovf = 1'b0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check_all("reset");
    RST = 1'b0;
    @(negedge CLOCK_50);
    check_all("post_reset");

    // Table-driven entry of A=5, B=3, OP=001 with req_ready low
    for (int i = 0; i < 3; i++) begin
      SW = vec[i].sw;
      press();
      model_press();
      chk($sformatf("tbl%0d_ledr", i), 32'(LEDR), 32'(vec[i].ledr));
      chk($sformatf("tbl%0d_hex5", i), 32'(HEX5), 32'(vec[i].h5));
      chk($sformatf("tbl%0d_hex4", i), 32'(HEX4), 32'(vec[i].h4));
      chk($sformatf("tbl%0d_hex3", i), 32'(HEX3), 32'(vec[i].h3));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk("stall_valid", 32'(req_valid), 32'd1);
      chk("stall_a",     32'(req_a),     32'd5);
      chk("stall_b",     32'(req_b),     32'd3);
      chk("stall_op",    32'(req_op),    32'd1);
    end
    SW = 4'd7;
    press();
    model_press();
    check_all("press_in_issue");
    req_ready = 1'b1;
    @(negedge CLOCK_50);
    req_ready = 1'b0;
    m_st = 4;
    chk("xfer_ledr",  32'(LEDR),      32'd4);
    chk("xfer_valid", 32'(req_valid), 32'd0);
    respond(2, 4'd2, 1'b0, 1'b0);
    chk("show_ledr", 32'(LEDR), 32'd5);
    chk("show_hex0", 32'(HEX0), 32'b0100100);
    chk("show_hex1", 32'(HEX1), 32'b1000000);
    press_model("show_clear");
    chk("clear_hex5", 32'(HEX5), 32'(BLANK));

    // Bounce: glitches shorter than the debounce window never advance
    for (int i = 0; i < 4; i++) begin
      KEY = 1'b0; @(negedge CLOCK_50);
      KEY = 1'b1; @(negedge CLOCK_50);
    end
    KEY = 1'b0; repeat (3) @(negedge CLOCK_50);
    KEY = 1'b1; repeat (10) @(negedge CLOCK_50);
    check_all("bounce");
    SW = 4'd9;
    press_model("clean_press");
    chk("clean_ledr", 32'(LEDR), 32'd1);

    // Timeout: no response, then a late one that must be ignored
    SW = 4'd4;  press_model("tmo_b");
    SW = 4'd5;  press_model("tmo_op");
    req_ready = 1'b1;
    @(negedge CLOCK_50);
    req_ready = 1'b0;
    m_st = 4;
    check_all("tmo_xfer");
    respond(9, 4'd3, 1'b1, 1'b1);
    chk("tmo_hex0", 32'(HEX0), 32'(GLYPH_E));
    chk("tmo_ledr", 32'(LEDR), 32'd5);

    // Response on the same cycle the timeout would fire
    enter_and_issue(4'd6, 4'd6, 3'd7, 1);
    respond(7, 4'd1, 1'b0, 1'b1);
    chk("tie_hex0", 32'(HEX0), 32'b1111001);
    chk("tie_hex2", 32'(HEX2), 32'b1111001);

    // Reset in the middle of WAIT_RSP, then a stray response
    enter_and_issue(4'd2, 4'd8, 3'd0, 0);
    repeat (2) @(negedge CLOCK_50);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge CLOCK_50);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1'b1; rsp_result = 4'hA; rsp_carry = 1'b1; rsp_ovf = 1'b1;
      @(negedge CLOCK_50);
      check_all("rst_stray");
    end
    rsp_valid = 1'b0;

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      rop = 3'($urandom);
      rr  = alu_ref(ra, rb, rop);
      rj  = $urandom_range(9, 0);
      enter_and_issue(ra, rb, rop, $urandom_range(3, 0));
      respond(rj, rr, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
